// File: rtl/dispatch_ctrl_if.sv
// Purpose : groups the instruction-queue / RS / ROB signals of the dispatch controller into one bundle.
// Latency : none; wires only.
// Backpressure: rs_full / rob_full / ifq_empty flow from the master side; pull/issue/alloc flow back from the slave.
// Ports   : master = queue/RS/ROB side (drives status, observes dispatch); slave = dispatch_ctrl.
interface dispatch_ctrl_if #(
    parameter int NUM_RS   = 4,
    parameter int RS_SEL_W = 2,
    parameter int CNT_W    = 16
);
    logic                ifq_empty;
    logic [RS_SEL_W-1:0] head_rs_sel;
    logic                head_is_branch;
    logic [NUM_RS-1:0]   rs_full;
    logic                rob_full;
    logic                br_resolved;
    logic                br_mispredict;
    logic                ifq_pull;
    logic [NUM_RS-1:0]   rs_issue;
    logic                rob_alloc;
    logic                flush;
    logic [1:0]          state_o;
    logic [CNT_W-1:0]    perf_stall_rs;
    logic [CNT_W-1:0]    perf_stall_rob;
    logic [CNT_W-1:0]    perf_stall_br;

    modport master (
        output ifq_empty, head_rs_sel, head_is_branch, rs_full, rob_full, br_resolved, br_mispredict,
        input  ifq_pull, rs_issue, rob_alloc, flush, state_o, perf_stall_rs, perf_stall_rob, perf_stall_br
    );

    modport slave (
        input  ifq_empty, head_rs_sel, head_is_branch, rs_full, rob_full, br_resolved, br_mispredict,
        output ifq_pull, rs_issue, rob_alloc, flush, state_o, perf_stall_rs, perf_stall_rob, perf_stall_br
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Purpose : pops the instruction-queue head into its reservation station, serialises past branches, flushes on mispredict.
// Latency : dispatch (ifq_pull/rs_issue/rob_alloc) is combinational, same cycle; flush is held FLUSH_CYCLES cycles.
// Backpressure: no pop while the target RS is full, the ROB is full, the select is invalid, or a branch is unresolved.
// Ports   : clk, rst (async, active-low) plus bus (dispatch_ctrl_if.slave) carrying queue head, RS/ROB status,
//           branch resolution, dispatch strobes, flush, state_o and three perf counters.
// Option  : `define DISPATCH_PERF_EN to implement the perf counters; otherwise they read constant 0.
module dispatch_ctrl #(
    parameter int NUM_RS       = 4,
    parameter int RS_SEL_W     = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    dispatch_ctrl_if.slave bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              sel_vld;
    logic              rs_busy;
    logic              go;
    logic [NUM_RS-1:0] issue_vec;

    // Decode the head's RS select without indexing rs_full out of range.
    always_comb begin
        sel_vld   = 1'b0;
        rs_busy   = 1'b0;
        issue_vec = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (bus.head_rs_sel == RS_SEL_W'(i)) begin
                sel_vld = 1'b1;
                rs_busy = bus.rs_full[i];
            end
        end
        // rst is folded in so the strobes stay low while reset is held.
        go = rst && (state_q == RUN) && !bus.ifq_empty && sel_vld && !rs_busy && !bus.rob_full;
        for (int i = 0; i < NUM_RS; i++) begin
            issue_vec[i] = go && (bus.head_rs_sel == RS_SEL_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (go && bus.head_is_branch) state_d = BR_WAIT;
            end
            BR_WAIT: begin
                if (bus.br_resolved) begin
                    if (bus.br_mispredict) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) state_d = RUN;
                else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ifq_pull  = go;
    assign bus.rob_alloc = go;
    assign bus.rs_issue  = issue_vec;
    assign bus.flush     = rst && (state_q == FLUSH);
    assign bus.state_o   = state_q;

`ifdef DISPATCH_PERF_EN
    logic [CNT_W-1:0] stall_rs_q, stall_rs_d;
    logic [CNT_W-1:0] stall_rob_q, stall_rob_d;
    logic [CNT_W-1:0] stall_br_q, stall_br_d;
    logic             rs_inc, rob_inc, br_inc;

    // Priority: empty queue counts nothing, then RS full/invalid, then ROB full.
    always_comb begin
        rs_inc  = (state_q == RUN) && !bus.ifq_empty && (!sel_vld || rs_busy);
        rob_inc = (state_q == RUN) && !bus.ifq_empty && sel_vld && !rs_busy && bus.rob_full;
        br_inc  = (state_q == BR_WAIT);
        stall_rs_d  = (rs_inc  && stall_rs_q  != '1) ? stall_rs_q  + CNT_W'(1) : stall_rs_q;
        stall_rob_d = (rob_inc && stall_rob_q != '1) ? stall_rob_q + CNT_W'(1) : stall_rob_q;
        stall_br_d  = (br_inc  && stall_br_q  != '1) ? stall_br_q  + CNT_W'(1) : stall_br_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_rs_q  <= '0;
            stall_rob_q <= '0;
            stall_br_q  <= '0;
        end else begin
            stall_rs_q  <= stall_rs_d;
            stall_rob_q <= stall_rob_d;
            stall_br_q  <= stall_br_d;
        end
    end

    assign bus.perf_stall_rs  = stall_rs_q;
    assign bus.perf_stall_rob = stall_rob_q;
    assign bus.perf_stall_br  = stall_br_q;
`else
    assign bus.perf_stall_rs  = '0;
    assign bus.perf_stall_rob = '0;
    assign bus.perf_stall_br  = '0;
`endif
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Purpose : directed checks of dispatch_ctrl: dispatch, RS/ROB stalls, branch wait, mispredict flush, async reset, saturation.
// Latency : inputs change 1 time unit after the rising edge; outputs are compared mid-cycle.
// Backpressure: driven directly by the stimulus sequence below.
module tb_dispatch_ctrl;
    localparam int NUM_RS       = 4;
    localparam int RS_SEL_W     = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
`ifdef DISPATCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dispatch_ctrl_if #(.NUM_RS(NUM_RS), .RS_SEL_W(RS_SEL_W), .CNT_W(CNT_W)) bus ();

    dispatch_ctrl #(
        .NUM_RS(NUM_RS), .RS_SEL_W(RS_SEL_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected perf value: counters read zero when the feature is compiled out.
    function automatic logic [31:0] pe(input int v);
        return PERF_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_disp(input string tag, input logic exp_pull, input logic [3:0] exp_issue);
        chk({tag, "_pull"},  32'(bus.ifq_pull),  32'(exp_pull));
        chk({tag, "_alloc"}, 32'(bus.rob_alloc), 32'(exp_pull));
        chk({tag, "_issue"}, 32'(bus.rs_issue),  32'(exp_issue));
    endtask

    initial begin
        rst                = 1'b0;
        bus.ifq_empty      = 1'b0;
        bus.head_rs_sel    = 3'd2;
        bus.head_is_branch = 1'b0;
        bus.rs_full        = 4'b0000;
        bus.rob_full       = 1'b0;
        bus.br_resolved    = 1'b0;
        bus.br_mispredict  = 1'b0;
        #2;
        // Reset held with a dispatchable head: strobes must stay low.
        chk_disp("rst", 1'b0, 4'b0000);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_prs", 32'(bus.perf_stall_rs), 32'd0);
        chk("rst_prob", 32'(bus.perf_stall_rob), 32'd0);
        chk("rst_pbr", 32'(bus.perf_stall_br), 32'd0);
        rst = 1'b1;

        // Plain dispatch to RS 2 for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            #4;
            chk_disp("run", 1'b1, 4'b0100);
            chk("run_state", 32'(bus.state_o), 32'd0);
        end

        // RS 2 full for five cycles, then clears.
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.rs_full = 4'b0100;
            #4;
            chk_disp("rsfull", 1'b0, 4'b0000);
        end
        tick();
        bus.rs_full = 4'b0000;
        #4;
        chk_disp("rsclr", 1'b1, 4'b0100);
        chk("rsclr_prs", 32'(bus.perf_stall_rs), pe(5));
        chk("rsclr_prob", 32'(bus.perf_stall_rob), 32'd0);

        // Out-of-range select: no dispatch, counted as an RS stall.
        tick();
        bus.head_rs_sel = 3'd5;
        #4;
        chk_disp("badsel", 1'b0, 4'b0000);
        tick();
        bus.head_rs_sel = 3'd2;
        #4;
        chk("badsel_prs", 32'(bus.perf_stall_rs), pe(6));
        chk_disp("badsel_after", 1'b1, 4'b0100);

        // Branch resolution is ignored in RUN.
        tick();
        bus.br_resolved   = 1'b1;
        bus.br_mispredict = 1'b1;
        #4;
        chk("runres_state", 32'(bus.state_o), 32'd0);
        chk_disp("runres", 1'b1, 4'b0100);
        tick();
        bus.br_resolved   = 1'b0;
        bus.br_mispredict = 1'b0;
        #4;
        chk("runres_state2", 32'(bus.state_o), 32'd0);
        chk("runres_flush", 32'(bus.flush), 32'd0);

        // Correctly predicted branch: four cycles of BR_WAIT.
        tick();
        bus.head_is_branch = 1'b1;
        bus.head_rs_sel    = 3'd0;
        #4;
        chk_disp("br_T", 1'b1, 4'b0001);
        for (int i = 1; i <= 4; i++) begin
            tick();
            bus.head_is_branch = 1'b0;
            bus.head_rs_sel    = 3'd1;
            bus.br_resolved    = (i == 4);
            bus.br_mispredict  = (i == 2);
            #4;
            chk("brwait_state", 32'(bus.state_o), 32'd1);
            chk_disp("brwait", 1'b0, 4'b0000);
        end
        tick();
        bus.br_resolved   = 1'b0;
        bus.br_mispredict = 1'b0;
        #4;
        chk("br_T5_state", 32'(bus.state_o), 32'd0);
        chk_disp("br_T5", 1'b1, 4'b0010);
        chk("br_T5_pbr", 32'(bus.perf_stall_br), pe(4));

        // Mispredict: FLUSH for exactly two cycles; resolution inside FLUSH ignored.
        tick();
        bus.head_is_branch = 1'b1;
        #4;
        chk_disp("mp_br", 1'b1, 4'b0010);
        tick();
        bus.head_is_branch = 1'b0;
        bus.br_resolved    = 1'b1;
        bus.br_mispredict  = 1'b1;
        #4;
        chk("mp_wait_state", 32'(bus.state_o), 32'd1);
        chk("mp_wait_flush", 32'(bus.flush), 32'd0);
        tick();
        #4;
        chk("mp_f1_state", 32'(bus.state_o), 32'd2);
        chk("mp_f1_flush", 32'(bus.flush), 32'd1);
        chk_disp("mp_f1", 1'b0, 4'b0000);
        tick();
        bus.br_resolved   = 1'b0;
        bus.br_mispredict = 1'b0;
        #4;
        chk("mp_f2_state", 32'(bus.state_o), 32'd2);
        chk("mp_f2_flush", 32'(bus.flush), 32'd1);
        tick();
        #4;
        chk("mp_end_state", 32'(bus.state_o), 32'd0);
        chk("mp_end_flush", 32'(bus.flush), 32'd0);
        chk_disp("mp_end", 1'b1, 4'b0010);
        chk("mp_end_pbr", 32'(bus.perf_stall_br), pe(5));

        // Asynchronous reset in the middle of a flush.
        tick();
        bus.head_is_branch = 1'b1;
        #4;
        tick();
        bus.head_is_branch = 1'b0;
        bus.br_resolved    = 1'b1;
        bus.br_mispredict  = 1'b1;
        #4;
        tick();
        bus.br_resolved   = 1'b0;
        bus.br_mispredict = 1'b0;
        #4;
        chk("arst_pre_flush", 32'(bus.flush), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_flush", 32'(bus.flush), 32'd0);
        chk("arst_state", 32'(bus.state_o), 32'd0);
        chk_disp("arst", 1'b0, 4'b0000);
        chk("arst_prs", 32'(bus.perf_stall_rs), 32'd0);
        chk("arst_pbr", 32'(bus.perf_stall_br), 32'd0);
        rst = 1'b1;
        #1;
        chk_disp("arst_rel", 1'b1, 4'b0010);
        chk("arst_rel_state", 32'(bus.state_o), 32'd0);

        // Stall priority: RS full beats ROB full; empty queue counts nothing.
        tick();
        bus.rs_full  = 4'b0010;
        bus.rob_full = 1'b1;
        #4;
        chk_disp("prio", 1'b0, 4'b0000);
        tick();
        bus.rs_full   = 4'b0000;
        bus.ifq_empty = 1'b1;
        #4;
        chk("prio_prs", 32'(bus.perf_stall_rs), pe(1));
        chk("prio_prob", 32'(bus.perf_stall_rob), 32'd0);
        chk_disp("empty", 1'b0, 4'b0000);
        tick();
        bus.ifq_empty = 1'b0;
        #4;
        chk("empty_prs", 32'(bus.perf_stall_rs), pe(1));
        chk("empty_prob", 32'(bus.perf_stall_rob), 32'd0);
        chk_disp("robfull", 1'b0, 4'b0000);

        // ROB full held: 4-bit counter saturates at 15.
        for (int k = 1; k <= 20; k++) begin
            tick();
            #4;
            if (k == 14) chk("sat_14", 32'(bus.perf_stall_rob), pe(14));
            if (k == 15) chk("sat_15", 32'(bus.perf_stall_rob), pe(15));
            if (k == 20) chk("sat_20", 32'(bus.perf_stall_rob), pe(15));
        end
        chk("sat_prs", 32'(bus.perf_stall_rs), pe(1));
        chk("sat_pbr", 32'(bus.perf_stall_br), 32'd0);
        chk_disp("sat", 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
